// File: rtl/tetris_gfx_pkg.sv
// Shared tile-graphics types: FSM state encoding, default tile geometry and the pixel record.
// The pixel record carries tile-local coordinates with the palette index.
package tetris_gfx_pkg;

    localparam int DEF_TILE_W = 20;
    localparam int DEF_TILE_H = 20;
    localparam int DEF_PIX_W  = 3;
    localparam int COORD_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [DEF_PIX_W-1:0] data;
    } pix_t;

endpackage

// File: rtl/tile_fifo2.sv
// Two-entry FIFO with registered storage; head visible combinationally, 1-cycle push-to-visible.
// Push is dropped when full, pop is ignored when empty; push+pop together keep occupancy.
module tile_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push_ok;
    logic         pop_ok;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/tile_fetch.sv
// Fetches one TILE_W x TILE_H tile from a 1-cycle ROM and streams pixels; first pixel 2 cycles after start.
// Issue is throttled so the 2-entry buffer never overflows under pix_ready backpressure; TILE_FETCH_TRANSPARENT_EN drops index-0 pixels.
module tile_fetch
    import tetris_gfx_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int TILE_H = DEF_TILE_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] read_address,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [4:0]        pix_x,
    output logic [4:0]        pix_y,
    output logic [PIX_W-1:0]  pix_data,
    output logic              busy,
    output logic              done
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(TILE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(TILE_H - 1);

    state_e             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, issue_addr;
    logic [COORD_W-1:0] cur_x, cur_y, issue_x, issue_y;
    logic               inflight, issue, last_issue, drain_end;
    logic               push, pop, full, empty;
    logic [2:0]         load;
    pix_t               push_pix, head_pix;

    assign pop = ~empty & pix_ready;

    // A pop in this cycle frees the slot the new read will land in two edges later.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_q;
        issue_x    = '0;
        issue_y    = '0;
        load       = {1'b0, full, ~full & ~empty} + {2'b00, inflight};
        case (state)
            IDLE: begin
                issue      = start;
                issue_addr = base_addr;
            end
            FETCH: begin
                issue      = (load < (3'd2 + {2'b00, pop}));
                issue_addr = addr_q + ADDR_W'(1);
                if (cur_x == X_LAST) begin
                    issue_x = '0;
                    issue_y = cur_y + COORD_W'(1);
                end else begin
                    issue_x = cur_x + COORD_W'(1);
                    issue_y = cur_y;
                end
            end
            default: ;
        endcase
    end

    assign last_issue = issue && (issue_x == X_LAST) && (issue_y == Y_LAST);
    assign drain_end  = (state == DRAIN) && !inflight && (empty || (!full && pop));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = last_issue ? DRAIN : FETCH;
            FETCH:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_end)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cur_x/cur_y always tag the read currently in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done     <= drain_end;
            if (issue) begin
                addr_q <= issue_addr;
                cur_x  <= issue_x;
                cur_y  <= issue_y;
            end
        end
    end

`ifdef TILE_FETCH_TRANSPARENT_EN
    assign push = inflight && (rom_data != '0);
`else
    assign push = inflight;
`endif

    assign push_pix = '{x: cur_x, y: cur_y, data: rom_data};

    tile_fifo2 #(
        .W($bits(pix_t))
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (push),
        .push_data (push_pix),
        .pop       (pop),
        .pop_data  (head_pix),
        .full      (full),
        .empty     (empty)
    );

    assign read_address = issue ? issue_addr : addr_q;
    assign busy         = (state != IDLE);
    assign pix_valid    = ~empty;
    assign pix_x        = head_pix.x;
    assign pix_y        = head_pix.y;
    assign pix_data     = head_pix.data;

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: ROM model, per-pixel expectation queue, immediate-assert checks.
module tb_tile_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        pix_ready = 1'b0;
    logic [18:0] base_addr = '0;
    logic [18:0] read_address;
    logic [2:0]  rom_data = '0;
    logic [2:0]  pix_data;
    logic        pix_valid, busy, done;
    logic [4:0]  pix_x, pix_y;

    logic [2:0]  rom [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          last_count = 0;
    int          exp_x[$], exp_y[$], exp_d[$], exp_off[$];

`ifdef TILE_FETCH_TRANSPARENT_EN
    localparam int T6_EXP = 200;
`else
    localparam int T6_EXP = 400;
`endif

    tile_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .read_address (read_address),
        .rom_data     (rom_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[read_address[9:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            1:       return c[0];
            2:       return (c > 50);
            default: return 1'b1;
        endcase
    endfunction

    // mode 0: ready high, 1: ready toggles, 2: ready low 50 cycles,
    // 3: extra start while busy, 4: reset while pixel 137 is presented
    task automatic run_tile(input int base, input int mode, input string tag);
        int  n_pix, pix_bad, n_done, done_c, post, frz_bad, max_addr, first_addr, idle_bad;
        bit  finished, timed;
        n_pix = 0; pix_bad = 0; n_done = 0; done_c = 0; post = 0;
        frz_bad = 0; idle_bad = 0; finished = 1'b0;
        timed = (mode == 0 || mode == 3 || mode == 4);
        exp_x.delete(); exp_y.delete(); exp_d.delete(); exp_off.delete();
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 20; x++) begin
                int   a;
                bit   keep;
                a = base + y * 20 + x;
                keep = 1'b1;
`ifdef TILE_FETCH_TRANSPARENT_EN
                keep = (rom[a] != 3'd0);
`endif
                if (keep) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                    exp_d.push_back(int'(rom[a]));
                    exp_off.push_back(y * 20 + x);
                end
            end
        end

        @(posedge Clk); #1;
        base_addr = 19'(base);
        start     = 1'b1;
        pix_ready = ready_for(mode, 0);
        #1;
        first_addr = int'(read_address);
        max_addr   = first_addr;

        for (int c = 1; c < 3000 && !finished; c++) begin
            @(posedge Clk); #1;
            start     = (mode == 3 && c == 10);
            base_addr = (mode == 3 && c == 10) ? 19'd777 : 19'(base);
            pix_ready = ready_for(mode, c);
            #1;
            if (int'(read_address) > max_addr) max_addr = int'(read_address);
            if (mode == 0 && c == 1) chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (mode == 2 && c >= 2 && c <= 50 &&
                (int'(read_address) != base + 1 || !pix_valid || int'(pix_x) != exp_x[0] ||
                 int'(pix_y) != exp_y[0] || int'(pix_data) != exp_d[0]))
                frz_bad++;
            if (mode == 2 && c == 51) chk({tag, "_release_addr"}, 32'(read_address), 32'(base + 2));
            if (done) begin
                n_done++;
                if (n_done == 1) done_c = c;
            end
            if (n_done > 0) begin
                post++;
                if (post == 3) finished = 1'b1;
            end
            if (mode == 4 && pix_valid && n_pix == 137) begin
                Reset_n = 1'b0;
                #1;
                chk({tag, "_rst_addr"},  32'(read_address), 32'd0);
                chk({tag, "_rst_valid"}, 32'(pix_valid), 32'd0);
                chk({tag, "_rst_x"},     32'(pix_x), 32'd0);
                chk({tag, "_rst_y"},     32'(pix_y), 32'd0);
                chk({tag, "_rst_data"},  32'(pix_data), 32'd0);
                chk({tag, "_rst_busy"},  32'(busy), 32'd0);
                chk({tag, "_rst_done"},  32'(done), 32'd0);
                finished = 1'b1;
            end else if (pix_valid && pix_ready) begin
                if (n_pix >= exp_x.size() || int'(pix_x) != exp_x[n_pix] ||
                    int'(pix_y) != exp_y[n_pix] || int'(pix_data) != exp_d[n_pix] ||
                    (timed && c != exp_off[n_pix] + 2))
                    pix_bad++;
                n_pix++;
            end
        end

        chk({tag, "_finished"}, 32'(finished), 32'd1);
        chk({tag, "_pix_bad"}, 32'(pix_bad), 32'd0);
        if (mode == 4) begin
            repeat (2) @(posedge Clk);
            #1 Reset_n = 1'b1;
            repeat (5) begin
                @(posedge Clk); #1;
                if (busy || pix_valid || done) idle_bad++;
            end
            chk({tag, "_idle_after_rst"}, 32'(idle_bad), 32'd0);
        end else begin
            chk({tag, "_count"}, 32'(n_pix), 32'(exp_x.size()));
            chk({tag, "_done_once"}, 32'(n_done), 32'd1);
            chk({tag, "_idle_end"}, {30'd0, busy, pix_valid}, 32'd0);
            if (timed) chk({tag, "_done_cycle"}, 32'(done_c), 32'd402);
            if (mode == 1) begin
                chk({tag, "_addr_lo"}, 32'(first_addr), 32'(base));
                chk({tag, "_addr_hi"}, 32'(max_addr), 32'(base + 399));
            end
            if (mode == 2) chk({tag, "_frozen"}, 32'(frz_bad), 32'd0);
        end
        last_count = n_pix;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 3'(a % 8);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_addr",  32'(read_address), 32'd0);
        chk("reset_valid", 32'(pix_valid), 32'd0);
        chk("reset_x",     32'(pix_x), 32'd0);
        chk("reset_y",     32'(pix_y), 32'd0);
        chk("reset_data",  32'(pix_data), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_done",  32'(done), 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        run_tile(0,   0, "t1_stream");
        run_tile(400, 1, "t2_toggle");
        run_tile(1,   2, "t3_hold");
        run_tile(0,   3, "t4_restart");
        run_tile(0,   4, "t5_reset");
        run_tile(0,   0, "t5_after");

        for (int a = 0; a < 1024; a++) rom[a] = a[0] ? 3'(a % 8) : 3'd0;
        run_tile(0, 0, "t6_transp");
        chk("t6_emitted", 32'(last_count), 32'(T6_EXP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
